demux8_rr_dispatcher: RTL

- Credit-based round-robin dispatcher that steers one input word stream to eight consumer lanes.
- Wraps the 1-to-8 demux function with sequencing. It picks the next eligible lane, asserts exactly one lane strobe per accepted word, and tracks per-lane buffer credits so no consumer is overrun.
- Sits between a single producer and eight downstream lane FIFOs.

---
 rtl/demux8_rr_dispatcher.sv | 101 ++++++++++
 1 files changed

// File: rtl/demux8_rr_dispatcher.sv
// Credit-based round-robin dispatcher: one producer stream steered to eight lanes,
// one registered lane strobe per accepted word, per-lane credits guard against overrun.
module demux8_rr_dispatcher #(
  parameter int DW      = 8,
  parameter int CREDITS = 4,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [7:0]    lane_en,
  input  logic [7:0]    credit_ret,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_sel,
  output logic          credit_err
);

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [CW-1:0] credit [8];
  logic [2:0]    ptr;
  logic [7:0]    eligible;
  logic [2:0]    grant;
  logic          accept;
  logic [7:0]    dec;
  logic [7:0]    overflow;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < 8; k++) begin
      eligible[k] = lane_en[k] && (credit[k] != '0);
    end
  end

  assign in_ready = |eligible;
  assign accept   = in_valid && in_ready;

  // Scan from ptr+7 down to ptr so the last hit is the first eligible lane after ptr.
  always_comb begin
    logic [2:0] idx;
    idx   = '0;
    grant = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (eligible[idx]) begin
        grant = idx;
      end
    end
  end

  always_comb begin
    dec      = '0;
    overflow = '0;
    for (int k = 0; k < 8; k++) begin
      dec[k]      = accept && (grant == 3'(k));
      overflow[k] = credit_ret[k] && !dec[k] && (credit[k] == CRED_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= '0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      out_valid <= '0;
      if (accept) begin
        out_valid <= 8'b1 << grant;
        out_data  <= in_data;
        out_sel   <= grant;
        ptr       <= grant + 3'd1;
      end
    end
  end

  // A simultaneous return and dispatch on one lane cancel; a return at full credit saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        credit[k] <= CRED_MAX;
      end
      credit_err <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (dec[k] && !credit_ret[k]) begin
          credit[k] <= credit[k] - 1'b1;
        end else if (credit_ret[k] && !dec[k] && !overflow[k]) begin
          credit[k] <= credit[k] + 1'b1;
        end
      end
      if (|overflow) begin
        credit_err <= 1'b1;
      end
    end
  end

endmodule
